// File: rtl/mvm_operand_sequencer.sv
// rtl/mvm_operand_sequencer.sv - sequences matrix/vector operand pairs into an external MAC and returns y = M*v row by row
module mvm_operand_sequencer #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(N*N)-1:0]   wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [DW-1:0]            mac_a,
    output logic [DW-1:0]            mac_b,
    output logic                     mac_en,
    output logic                     mac_clr,
    input  logic [AW-1:0]            mac_f,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N)-1:0]     res_idx,
    output logic [AW-1:0]            res_data
);

    localparam int AWD = $clog2(N*N);
    localparam int IW  = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, CAPTURE, OUT, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  row;
    logic [IW-1:0]  col;
    logic [IW-1:0]  col_nx;
    logic [DW-1:0]  mat [N*N];
    logic [DW-1:0]  vec [N];

    function automatic logic [AWD-1:0] flat(input logic [IW-1:0] r, input logic [IW-1:0] c);
        flat = AWD'(r) * AWD'(N) + AWD'(c);
    endfunction

    assign col_nx = col + IW'(1);

    // Host writes land only while idle so operands never change under a running product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N*N; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++)   vec[i] <= '0;
        end else if (wr_en && !busy) begin
            if (wr_sel) vec[wr_addr[IW-1:0]] <= wr_data;
            else        mat[wr_addr]         <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        row     <= '0;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= ISSUE;
                    col     <= '0;
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b1;
                    mac_a   <= mat[flat(row, '0)];
                    mac_b   <= vec[0];
                end
                ISSUE: begin
                    if (col == LAST) begin
                        state  <= CAPTURE;
                        mac_en <= 1'b0;
                        mac_a  <= '0;
                        mac_b  <= '0;
                    end else begin
                        col   <= col_nx;
                        mac_a <= mat[flat(row, col_nx)];
                        mac_b <= vec[col_nx];
                    end
                end
                CAPTURE: begin
                    // The final accumulate landed on the previous edge, so mac_f is complete here
                    state     <= OUT;
                    res_data  <= mac_f;
                    res_idx   <= row;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (row == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= CLEAR;
                            row     <= row + IW'(1);
                            mac_clr <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_operand_sequencer.sv
// tb/tb_mvm_operand_sequencer.sv - table-driven bench for mvm_operand_sequencer with a behavioural MAC
module tb_mvm_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, wr_sel, start, res_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy, done, mac_en, mac_clr, res_valid;
    logic [7:0]  mac_a, mac_b;
    logic [15:0] mac_f, res_data;
    logic [1:0]  res_idx;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mvm_operand_sequencer #(.N(4), .DW(8), .AW(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .mac_a(mac_a),
        .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr), .mac_f(mac_f),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data)
    );

    // External MAC unit
    logic        [15:0] acc;
    wire  signed [15:0] prod = $signed(mac_a) * $signed(mac_b);
    assign mac_f = acc;
    always @(posedge clk or negedge reset) begin
        if (!reset)       acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_en)  acc <= acc + prod;
    end

    typedef struct {
        logic [127:0] m;
        logic [31:0]  v;
        logic [63:0]  e;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wr(input logic sel, input int addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic run(input vec_t t, input string name, input bit load, input int stall_row,
                       input int stall_len, input int poke_cyc, input int abort_cyc);
        int nres = 0;
        int first = -1;
        int dcyc = -1;
        int stalled = 0;
        bit expect_clr = 0;
        logic [15:0] held;
        if (load) begin
            for (int i = 0; i < 16; i++) wr(1'b0, i, t.m[i*8 +: 8]);
            for (int i = 0; i < 4; i++)  wr(1'b1, i, t.v[i*8 +: 8]);
        end
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            if (expect_clr) begin
                check({name, " clear_after_accept"}, 32'(mac_clr), 32'd1);
                expect_clr = 0;
            end
            if (cyc == abort_cyc) begin
                reset = 1'b0;
                #1;
                check({name, " abort_ctl"}, {27'd0, busy, done, mac_en, mac_clr, res_valid}, 32'd0);
                check({name, " abort_data"}, {mac_a, mac_b, res_data}, 32'd0);
                check({name, " abort_idx"}, 32'(res_idx), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (cyc == poke_cyc) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (res_valid) begin
                if (first < 0) first = cyc;
                if (int'(res_idx) == stall_row && stalled < stall_len) begin
                    if (stalled == 0) held = res_data;
                    else check($sformatf("%s stall_hold c%0d", name, cyc), {14'd0, res_idx, res_data},
                               {14'd0, 2'(stall_row), held});
                    check($sformatf("%s stall_mac c%0d", name, cyc), {14'd0, mac_en, mac_clr, mac_a, mac_b}, 32'd0);
                    res_ready = 1'b0;
                    stalled++;
                end else begin
                    check($sformatf("%s idx%0d", name, nres), 32'(res_idx), 32'(nres));
                    check($sformatf("%s data%0d", name, nres), 32'(res_data), 32'(t.e[(nres%4)*16 +: 16]));
                    if (stall_len > 0 && int'(res_idx) == stall_row) expect_clr = 1;
                    nres++;
                    res_ready = 1'b1;
                end
            end else begin
                res_ready = 1'b1;
            end
            if (done) begin
                dcyc = cyc;
                check({name, " busy_in_done"}, 32'(busy), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        check({name, " first_valid_cycle"}, 32'(first), 32'd7);
        check({name, " done_cycle"}, 32'(dcyc), 32'(29 + stall_len));
        check({name, " result_count"}, 32'(nres), 32'd4);
        @(posedge clk); #1;
        check({name, " idle_after_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; res_ready = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tbl[k].m = '0; tbl[k].v = '0; tbl[k].e = '0;
        end
        for (int r = 0; r < 4; r++) begin
            tbl[0].m[(r*4+r)*8 +: 8] = 8'd1;
            tbl[0].v[r*8 +: 8] = 8'(r + 1);
            tbl[0].e[r*16 +: 16] = 16'(r + 1);
            tbl[1].m[r*32 +: 32] = {8'd4, 8'hFD, 8'd2, 8'hFF};
            tbl[1].e[r*16 +: 16] = 16'h0012;
            tbl[3].m[r*32 +: 32] = {8'(r), 8'd30, 8'd20, 8'd10};
            tbl[3].v[r*8 +: 8] = 8'hFF;
            tbl[3].e[r*16 +: 16] = 16'hFFC4 - 16'(r);
        end
        tbl[1].v = {8'd8, 8'd7, 8'd6, 8'd5};
        tbl[2].m[15:0] = 16'h8080;
        tbl[2].v[15:0] = 16'h8080;
        tbl[2].e[15:0] = 16'h8000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {27'd0, busy, done, mac_en, mac_clr, res_valid}, 32'd0);
        check("reset_data", {mac_a, mac_b, res_data}, 32'd0);
        check("reset_idx", 32'(res_idx), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++)
            run(tbl[k], $sformatf("vec%0d", k), 1, -1, 0, -1, -1);

        run(tbl[0], "stall", 1, 1, 5, -1, -1);
        run(tbl[0], "poke", 0, -1, 0, 3, -1);
        run(tbl[0], "after_poke", 0, -1, 0, -1, -1);
        run(tbl[1], "abort", 1, -1, 0, -1, 17);
        run(tbl[4], "post_reset", 0, -1, 0, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mvm_operand_sequencer.md
# mvm_operand_sequencer

Drives operand pairs into an external signed multiply-accumulate unit (8-bit operands, 16-bit registered accumulator) and collects its results, computing y = M·v for an N×N signed matrix and N-element signed vector held in local registers. It is the initiator for the MAC's a/b/f interface. It sits between the host load/result interface and one MAC instance.

## Interface
Parameters:
- N, 4, matrix dimension and vector length (N ≥ 2)
- DW, 8, operand width, signed two's complement
- AW, 16, accumulator/result width, signed

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- wr_en  in  1  load strobe, honoured only when busy=0
- wr_sel  in  1  0 = matrix, 1 = vector
- wr_addr  in  $clog2(N*N)  matrix: row*N+col; vector: low $clog2(N) bits = element index
- wr_data  in  DW  operand to store
- start  in  1  begin computation, honoured only when busy=0
- busy  out  1  high from cycle after start accepted until done
- done  out  1  one-cycle pulse after last result accepted
- mac_a  out  DW  matrix element to MAC
- mac_b  out  DW  vector element to MAC
- mac_en  out  1  MAC accumulates a*b this edge
- mac_clr  out  1  MAC clears accumulator this edge
- mac_f  in  AW  MAC registered accumulator
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- res_idx  out  $clog2(N)  row index of result
- res_data  out  AW  y[res_idx]

## Operation
- MAC contract: each rising edge, acc <= mac_clr ? 0 : mac_en ? acc + a*b (wrap mod 2^AW) : acc; mac_f = acc. mac_clr has priority over mac_en.
- Storage: N*N matrix and N vector registers, all cleared to 0 by reset. Writes while busy=1 are dropped.
- FSM states: IDLE, CLEAR, ISSUE, CAPTURE, OUT, DONE.
  - IDLE: start=1 → CLEAR, row=0, busy=1.
  - CLEAR: mac_clr=1 for one cycle → ISSUE, col=0.
  - ISSUE: mac_en=1, mac_a=M[row][col], mac_b=v[col]; col increments; after col=N-1 → CAPTURE.
  - CAPTURE: mac_en=0; register mac_f into res_data, row into res_idx → OUT.
  - OUT: res_valid=1; on handshake → CLEAR with row+1, or → DONE if row=N-1.
  - DONE: done=1 one cycle, busy=0 next cycle → IDLE.
- All outputs registered/state-decoded; mac_a/mac_b = 0 outside ISSUE.
- Arithmetic: sums wrap in two's complement at AW bits; no saturation, no overflow flag.
- start while busy: ignored. start in the DONE cycle: ignored.

## Timing
- Reset (any state, asynchronous): state IDLE; busy, done, mac_en, mac_clr, res_valid = 0; mac_a, mac_b, res_idx, res_data = 0; storage zeroed. Operation in flight is abandoned, no result or done emitted.
- Start sampled at edge E0: CLEAR occupies cycle 1, ISSUE cycles 2..N+1, CAPTURE cycle N+2, res_valid first high cycle N+3.
- Per row with res_ready held high: N+3 cycles. Full matrix: N·(N+3) cycles, done high in cycle N·(N+3)+1.
- res_valid stays high and res_idx/res_data stable until accepted; no MAC activity (mac_en=mac_clr=0) while stalled in OUT.
- Results delivered strictly in row order 0..N-1, exactly once each.

## Test plan
- Identity M, v=[1,2,3,4], res_ready=1 → results (0,1),(1,2),(2,3),(3,4); first res_valid 7 cycles after start edge, done 29 cycles after start edge.
- Every row [-1,2,-3,4], v=[5,6,7,8] → all four results = 18 (0x0012).
- Row 0 = [-128,-128,0,0], v=[-128,-128,0,0] → res_data = 0x8000 (32768 wraps to -32768); other rows 0.
- res_ready low 5 cycles at row 1 → res_valid held, res_data/res_idx stable, mac_en/mac_clr low; CLEAR for row 2 in cycle after accept.
- Pulse start and wr_en (M[0]=99) mid-ISSUE → no restart, result unchanged, M[0] keeps old value on next run.
- Assert reset low during row 2 ISSUE → all outputs 0 immediately; after release, start → four results of 0 and done.
